fpaddsub_round_pack_stage: RTL

Final stage of the pipelined single-precision FP add/sub datapath. It sits directly downstream of the normalize-shift stage and consumes its normalized mantissa, adjusted exponent, round/sticky bits and zero/negative-exponent flags. It applies round-to-nearest-even, corrects the exponent on mantissa carry-out and resolves exceptions (NaN, Inf, overflow, underflow/flush-to-zero). It then packs an IEEE-754 word behind a two-register elastic valid/ready pipeline.

---
 rtl/fpaddsub_round_pack_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fpaddsub_round_pack_stage.sv
// rtl/fpaddsub_round_pack_stage.sv - FP add/sub round, exception resolve and pack stage
module fpaddsub_round_pack_stage #(
  parameter int EXP_BITS = 8,
  parameter int MAN_BITS = 23,
  parameter int RNE_EN   = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [MAN_BITS-1:0]          NormM,
  input  logic [EXP_BITS:0]            NormE,
  input  logic                         ZeroSum,
  input  logic                         NegE,
  input  logic                         R,
  input  logic                         S,
  input  logic                         Sign,
  input  logic                         InNaN,
  input  logic                         InInf,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [EXP_BITS+MAN_BITS:0]   Z,
  output logic                         Overflow,
  output logic                         Underflow,
  output logic                         Inexact
);

  localparam logic                LP_RNE     = (RNE_EN != 0);
  localparam logic [EXP_BITS+1:0] LP_E_MAX   = {2'b00, {EXP_BITS{1'b1}}};
  localparam logic [EXP_BITS+1:0] LP_E_ZERO  = '0;

  // Stage A state: rounded mantissa plus everything stage B needs to resolve the result
  logic                  r_va;
  logic [MAN_BITS-1:0]   r_a_m;
  logic                  r_a_cout;
  logic [EXP_BITS:0]     r_a_e;
  logic                  r_a_sign;
  logic                  r_a_zero;
  logic                  r_a_nege;
  logic                  r_a_nan;
  logic                  r_a_inf;
  logic                  r_a_inx;

  // Stage B state: the packed word and flags presented downstream
  logic                        r_vb;
  logic [EXP_BITS+MAN_BITS:0]  r_z;
  logic                        r_ovf;
  logic                        r_unf;
  logic                        r_inx;

  logic                  w_a_load;
  logic                  w_b_load;
  logic                  w_round_up;
  logic [MAN_BITS:0]     w_mr;
  logic [EXP_BITS+1:0]   w_e;

  logic [EXP_BITS+MAN_BITS:0]  w_z_nxt;
  logic                        w_ovf_nxt;
  logic                        w_unf_nxt;
  logic                        w_inx_nxt;

  // A stage can take a new item whenever its current content is free to move on into B
  assign w_a_load = ~r_va | ~r_vb | OutReady;
  assign w_b_load = ~r_vb | OutReady;
  assign InReady  = ~RST & w_a_load;

  // Round-to-nearest-even: increment on R with either sticky or an odd LSB (tie-to-even)
  assign w_round_up = LP_RNE & R & (S | NormM[0]);
  assign w_mr       = {1'b0, NormM} + {{MAN_BITS{1'b0}}, w_round_up};

  // Mantissa carry bumps the exponent; the wrapped mantissa field is already zero
  assign w_e = {1'b0, r_a_e} + {{(EXP_BITS+1){1'b0}}, r_a_cout};

  // Exception priority: NaN, Inf, exact zero, underflow flush, overflow, normal pack
  always_comb begin
    w_z_nxt   = '0;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    w_inx_nxt = 1'b0;
    if (r_a_nan) begin
      w_z_nxt = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
    end else if (r_a_inf) begin
      w_z_nxt = {r_a_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
    end else if (r_a_zero) begin
      w_z_nxt = {r_a_sign, {(EXP_BITS+MAN_BITS){1'b0}}};
    end else if (r_a_nege || (w_e == LP_E_ZERO)) begin
      w_z_nxt   = {r_a_sign, {(EXP_BITS+MAN_BITS){1'b0}}};
      w_unf_nxt = 1'b1;
      w_inx_nxt = 1'b1;
    end else if (w_e >= LP_E_MAX) begin
      w_z_nxt   = {r_a_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      w_ovf_nxt = 1'b1;
      w_inx_nxt = 1'b1;
    end else begin
      w_z_nxt   = {r_a_sign, w_e[EXP_BITS-1:0], r_a_m};
      w_inx_nxt = r_a_inx;
    end
  end

  // Stage A register: capture rounded mantissa and side information
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_va     <= 1'b0;
      r_a_m    <= '0;
      r_a_cout <= 1'b0;
      r_a_e    <= '0;
      r_a_sign <= 1'b0;
      r_a_zero <= 1'b0;
      r_a_nege <= 1'b0;
      r_a_nan  <= 1'b0;
      r_a_inf  <= 1'b0;
      r_a_inx  <= 1'b0;
    end else if (w_a_load) begin
      r_va <= InValid;
      if (InValid) begin
        r_a_m    <= w_mr[MAN_BITS-1:0];
        r_a_cout <= w_mr[MAN_BITS];
        r_a_e    <= NormE;
        r_a_sign <= Sign;
        r_a_zero <= ZeroSum;
        r_a_nege <= NegE;
        r_a_nan  <= InNaN;
        r_a_inf  <= InInf;
        r_a_inx  <= R | S;
      end
    end
  end

  // Stage B register: holds result steady while downstream stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vb  <= 1'b0;
      r_z   <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_inx <= 1'b0;
    end else if (w_b_load) begin
      r_vb <= r_va;
      if (r_va) begin
        r_z   <= w_z_nxt;
        r_ovf <= w_ovf_nxt;
        r_unf <= w_unf_nxt;
        r_inx <= w_inx_nxt;
      end
    end
  end

  assign OutValid  = r_vb;
  assign Z         = r_z;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign Inexact   = r_inx;

endmodule
